// File: rtl/quad_encoder_emulator_if.sv
// Command interface of the quadrature encoder emulator.
// Groups the command handshake, the per-command fields and the abort request.
//   cmd_valid     : command request from the issuer
//   cmd_ready     : emulator is idle and will accept a command this cycle
//   cmd_clockwise : rotation direction
//   cmd_clicks    : detent count (4 quadrature steps per detent)
//   cmd_press     : append a switch press/release after the rotation
//   step_period   : clocks per quadrature step (0 behaves as 1)
//   abort         : cancel the active command
interface quad_encoder_emulator_if #(
    parameter int CNT_W    = 8,
    parameter int PERIOD_W = 24
);
    logic                cmd_valid;
    logic                cmd_ready;
    logic                cmd_clockwise;
    logic [CNT_W-1:0]    cmd_clicks;
    logic                cmd_press;
    logic [PERIOD_W-1:0] step_period;
    logic                abort;

    modport master (
        output cmd_valid, cmd_clockwise, cmd_clicks, cmd_press, step_period, abort,
        input  cmd_ready
    );

    modport slave (
        input  cmd_valid, cmd_clockwise, cmd_clicks, cmd_press, step_period, abort,
        output cmd_ready
    );
endinterface

// File: rtl/quad_encoder_emulator.sv
// Quadrature encoder emulator: turns rotate/press commands into clean A/B
// quadrature waveforms and a push-switch level, for loop-back self-test of the
// encoder input path and for bench stimulus.
// Ports:
//   i_clk        : system clock
//   i_reset      : synchronous active-low reset
//   cmd          : command interface (slave side)
//   o_enc_A/B    : quadrature phases, {B,A} is the current phase
//   o_enc_sw     : switch level, 1 = pressed
//   o_busy       : a command is in progress
//   o_step_stb   : one-clock pulse with every A/B change
//   o_done_stb   : one-clock pulse on normal command completion
//
// state  | meaning
// IDLE   | waiting for a command, cmd_ready high
// ROTATE | emitting one quadrature step per step period
// SETTLE | one quiet step period after the rotation
// PRESS  | switch held pressed for PRESS_STEPS step periods
// GAP    | switch released, waiting PRESS_STEPS step periods
// FINISH | done_stb pulse, then back to IDLE
module quad_encoder_emulator #(
    parameter int CNT_W       = 8,
    parameter int PERIOD_W    = 24,
    parameter int PRESS_STEPS = 8
) (
    input  logic                     i_clk,
    input  logic                     i_reset,
    quad_encoder_emulator_if.slave   cmd,
    output logic                     o_enc_A,
    output logic                     o_enc_B,
    output logic                     o_enc_sw,
    output logic                     o_busy,
    output logic                     o_step_stb,
    output logic                     o_done_stb
);
    localparam int STEP_W = CNT_W + 2;
    localparam int PCNT_W = $clog2(PRESS_STEPS + 1);

    typedef enum logic [2:0] {
        ST_IDLE, ST_ROTATE, ST_SETTLE, ST_PRESS, ST_GAP, ST_FINISH
    } state_t;

    state_t              r_state;
    logic [1:0]          r_phase;
    logic                r_sw;
    logic                r_step_stb;
    logic                r_done_stb;
    logic [PERIOD_W-1:0] r_timer;
    logic [PERIOD_W-1:0] r_period;
    logic                r_cw;
    logic                r_press;
    logic [STEP_W-1:0]   r_steps;
    logic [PCNT_W-1:0]   r_cnt;

    logic                w_accept;
    logic                w_tick;
    logic [PERIOD_W-1:0] w_period;
    logic [STEP_W-1:0]   w_steps;
    logic [1:0]          w_next_phase;

    assign cmd.cmd_ready = (r_state == ST_IDLE) && i_reset;
    assign w_accept      = cmd.cmd_valid && cmd.cmd_ready;
    assign w_tick        = (r_timer == '0);
    assign w_period      = (cmd.step_period == '0) ? PERIOD_W'(1) : cmd.step_period;
    assign w_steps       = {cmd.cmd_clicks, 2'b00};

    // {B,A}: clockwise B<=A, A<=~B; counter-clockwise B<=~A, A<=B.
    assign w_next_phase = r_cw ? {r_phase[0], ~r_phase[1]} : {~r_phase[0], r_phase[1]};

    always_ff @(posedge i_clk) begin
        if (!i_reset) begin
            r_state    <= ST_IDLE;
            r_phase    <= 2'b00;
            r_sw       <= 1'b0;
            r_step_stb <= 1'b0;
            r_done_stb <= 1'b0;
            r_timer    <= '0;
            r_period   <= PERIOD_W'(1);
            r_cw       <= 1'b0;
            r_press    <= 1'b0;
            r_steps    <= '0;
            r_cnt      <= '0;
        end else begin
            r_step_stb <= 1'b0;
            r_done_stb <= 1'b0;

            // Free-running step timer while a command is active; reload on tick.
            if (r_state != ST_IDLE) begin
                r_timer <= w_tick ? (r_period - PERIOD_W'(1)) : (r_timer - PERIOD_W'(1));
            end

            // Abort wins over any tick on the same edge; phase is left as-is.
            if (r_state != ST_IDLE && cmd.abort) begin
                r_state <= ST_IDLE;
                r_sw    <= 1'b0;
            end else begin
                case (r_state)
                    ST_IDLE: begin
                        if (w_accept) begin
                            r_cw     <= cmd.cmd_clockwise;
                            r_press  <= cmd.cmd_press;
                            r_steps  <= w_steps;
                            r_period <= w_period;
                            r_timer  <= w_period - PERIOD_W'(1);
                            if (w_steps != '0)
                                r_state <= ST_ROTATE;
                            else if (cmd.cmd_press)
                                r_state <= ST_SETTLE;
                            else
                                r_state <= ST_FINISH;
                        end
                    end
                    ST_ROTATE: begin
                        if (w_tick) begin
                            r_phase    <= w_next_phase;
                            r_step_stb <= 1'b1;
                            r_steps    <= r_steps - STEP_W'(1);
                            if (r_steps == STEP_W'(1))
                                r_state <= ST_SETTLE;
                        end
                    end
                    ST_SETTLE: begin
                        if (w_tick) begin
                            if (r_press) begin
                                r_sw    <= 1'b1;
                                r_cnt   <= PCNT_W'(PRESS_STEPS);
                                r_state <= ST_PRESS;
                            end else begin
                                r_done_stb <= 1'b1;
                                r_state    <= ST_FINISH;
                            end
                        end
                    end
                    ST_PRESS: begin
                        if (w_tick) begin
                            if (r_cnt == PCNT_W'(1)) begin
                                r_sw    <= 1'b0;
                                r_cnt   <= PCNT_W'(PRESS_STEPS);
                                r_state <= ST_GAP;
                            end else begin
                                r_cnt <= r_cnt - PCNT_W'(1);
                            end
                        end
                    end
                    ST_GAP: begin
                        if (w_tick) begin
                            if (r_cnt == PCNT_W'(1)) begin
                                r_done_stb <= 1'b1;
                                r_state    <= ST_FINISH;
                            end else begin
                                r_cnt <= r_cnt - PCNT_W'(1);
                            end
                        end
                    end
                    ST_FINISH: begin
                        // Entered with the pulse already raised from a timed
                        // path; an empty command arrives here without it and
                        // raises it one clock later.
                        if (!r_done_stb)
                            r_done_stb <= 1'b1;
                        else
                            r_state <= ST_IDLE;
                    end
                    default: r_state <= ST_IDLE;
                endcase
            end
        end
    end

    assign o_enc_A    = r_phase[0];
    assign o_enc_B    = r_phase[1];
    assign o_enc_sw   = r_sw;
    assign o_busy     = (r_state != ST_IDLE);
    assign o_step_stb = r_step_stb;
    assign o_done_stb = r_done_stb;
endmodule

// File: tb/tb_quad_encoder_emulator.sv
module tb_quad_encoder_emulator;
    localparam int CNT_W = 8;
    localparam int PERIOD_W = 24;
    localparam int PS = 8;
    localparam int K_STEP = 0;
    localparam int K_SW = 1;
    localparam int K_DONE = 2;

    typedef struct {
        longint     cyc;
        int         kind;
        logic [1:0] val;
    } ev_t;

    logic clk = 1'b0;
    logic rst_n;
    logic enc_A, enc_B, enc_sw, busy, step_stb, done_stb;
    longint cyc = 0;
    int n_tests = 0;
    int n_fail = 0;
    bit mon_on = 1'b0;
    ev_t q[$];
    logic [1:0] gray [4];
    int pos = 0;
    logic [1:0] prev_ph;
    logic prev_sw;

    quad_encoder_emulator_if #(.CNT_W(CNT_W), .PERIOD_W(PERIOD_W)) bus ();

    quad_encoder_emulator #(.CNT_W(CNT_W), .PERIOD_W(PERIOD_W), .PRESS_STEPS(PS)) dut (
        .i_clk      (clk),
        .i_reset    (rst_n),
        .cmd        (bus),
        .o_enc_A    (enc_A),
        .o_enc_B    (enc_B),
        .o_enc_sw   (enc_sw),
        .o_busy     (busy),
        .o_step_stb (step_stb),
        .o_done_stb (done_stb)
    );

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    task automatic check_ev(input int kind, input logic [1:0] val);
        ev_t e;
        n_tests++;
        if (q.size() == 0) begin
            n_fail++;
            $display("FAIL unexpected_event kind=%0d val=%b at cycle %0d, none expected", kind, val, cyc);
        end else begin
            e = q.pop_front();
            if (e.kind != kind || e.cyc != cyc || e.val != val) begin
                n_fail++;
                $display("FAIL event got kind=%0d val=%b cyc=%0d, expected kind=%0d val=%b cyc=%0d",
                         kind, val, cyc, e.kind, e.val, e.cyc);
            end
        end
    endtask

    // Monitor: every observable output event is matched against the queue.
    always @(negedge clk) begin
        if (mon_on) begin
            while (q.size() > 0 && q[0].cyc < cyc) begin
                n_tests++;
                n_fail++;
                $display("FAIL missed_event kind=%0d val=%b expected at cycle %0d, now %0d",
                         q[0].kind, q[0].val, q[0].cyc, cyc);
                void'(q.pop_front());
            end
            if (step_stb)
                check_ev(K_STEP, {enc_B, enc_A});
            else if ({enc_B, enc_A} != prev_ph) begin
                n_tests++;
                n_fail++;
                $display("FAIL phase_change_without_strobe got %b, expected %b at cycle %0d",
                         {enc_B, enc_A}, prev_ph, cyc);
            end
            if (enc_sw != prev_sw)
                check_ev(K_SW, {1'b0, enc_sw});
            if (done_stb)
                check_ev(K_DONE, 2'b00);
            prev_ph = {enc_B, enc_A};
            prev_sw = enc_sw;
        end
    end

    task automatic finish_run();
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    endtask

    // abort_off: -1 none, 0 random edge inside the command, >0 offset from accept.
    task automatic run_cmd(input bit cw, input int clicks, input bit press, input int per,
                           input int abort_off, input bit garbage);
        longint t, ab, done_e, rise, fall, rc, exp_rc;
        int P, S, bound;
        bit seen, do_abort;
        @(negedge clk);
        t = cyc + 1;
        P = (per == 0) ? 1 : per;
        S = 4 * clicks;
        rise = 0;
        fall = 0;
        if (press) begin
            rise = t + longint'(S + 1) * P;
            fall = rise + longint'(PS) * P;
            done_e = fall + longint'(PS) * P;
        end else if (S == 0) begin
            done_e = t + 1;
        end else begin
            done_e = t + longint'(S + 1) * P;
        end
        do_abort = (abort_off >= 0);
        if (abort_off > 0) ab = t + abort_off;
        else if (abort_off == 0) ab = t + $urandom_range(1, int'(done_e - t));
        else ab = done_e + 64'd1000000;

        for (int k = 1; k <= S; k++) begin
            if (t + longint'(k) * P < ab) begin
                pos = cw ? (pos + 1) % 4 : (pos + 3) % 4;
                q.push_back('{t + longint'(k) * P, K_STEP, gray[pos]});
            end
        end
        if (press) begin
            if (rise < ab) q.push_back('{rise, K_SW, 2'b01});
            if (fall < ab) q.push_back('{fall, K_SW, 2'b00});
            else if (rise < ab) q.push_back('{ab, K_SW, 2'b00});
        end
        if (!do_abort) q.push_back('{done_e, K_DONE, 2'b00});

        bus.cmd_valid = 1'b1;
        bus.cmd_clockwise = cw;
        bus.cmd_clicks = CNT_W'(clicks);
        bus.cmd_press = press;
        bus.step_period = PERIOD_W'(per);

        bound = int'(done_e - t) + 20;
        seen = 1'b0;
        rc = 0;
        for (int i = 0; i < bound && !seen; i++) begin
            @(negedge clk);
            bus.abort = do_abort && (cyc == ab - 1);
            if (bus.cmd_ready) begin
                seen = 1'b1;
                rc = cyc;
                bus.cmd_valid = 1'b0;
            end else if (garbage) begin
                bus.cmd_valid = 1'b1;
                bus.cmd_clockwise = 1'($urandom);
                bus.cmd_clicks = CNT_W'($urandom);
                bus.cmd_press = 1'($urandom);
                bus.step_period = PERIOD_W'($urandom_range(0, 7));
            end else begin
                bus.cmd_valid = 1'b0;
            end
        end
        bus.abort = 1'b0;
        if (!seen) begin
            n_tests++;
            n_fail++;
            $display("FAIL ready_timeout no cmd_ready within %0d cycles of accept at %0d", bound, t);
            $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
            $fatal(1, "stuck");
        end
        exp_rc = do_abort ? ab : done_e + 1;
        n_tests++;
        if (rc != exp_rc) begin
            n_fail++;
            $display("FAIL ready_cycle got %0d, expected %0d (accept %0d)", rc, exp_rc, t);
        end
        n_tests++;
        if ({enc_B, enc_A, enc_sw, busy} != {gray[pos], 1'b0, 1'b0}) begin
            n_fail++;
            $display("FAIL idle_outputs got BA=%b sw=%b busy=%b, expected BA=%b sw=0 busy=0",
                     {enc_B, enc_A}, enc_sw, busy, gray[pos]);
        end
    endtask

    initial begin
        gray[0] = 2'b00;
        gray[1] = 2'b01;
        gray[2] = 2'b11;
        gray[3] = 2'b10;
        rst_n = 1'b0;
        bus.cmd_valid = 1'b1;
        bus.cmd_clockwise = 1'b1;
        bus.cmd_clicks = CNT_W'(3);
        bus.cmd_press = 1'b1;
        bus.step_period = PERIOD_W'(1);
        bus.abort = 1'b0;

        repeat (3) begin
            @(negedge clk);
            n_tests++;
            if ({enc_A, enc_B, enc_sw, busy, step_stb, done_stb, bus.cmd_ready} != 7'b0) begin
                n_fail++;
                $display("FAIL reset_outputs got A,B,sw,busy,step,done,ready=%b, expected 0000000",
                         {enc_A, enc_B, enc_sw, busy, step_stb, done_stb, bus.cmd_ready});
            end
        end
        rst_n = 1'b1;
        bus.cmd_valid = 1'b0;
        @(negedge clk);
        n_tests++;
        if ({bus.cmd_ready, busy, enc_A, enc_B} != 4'b1000) begin
            n_fail++;
            $display("FAIL after_reset got ready,busy,A,B=%b, expected 1000",
                     {bus.cmd_ready, busy, enc_A, enc_B});
        end
        prev_ph = {enc_B, enc_A};
        prev_sw = enc_sw;
        mon_on = 1'b1;

        run_cmd(1'b1, 2, 1'b0, 4, -1, 1'b1);
        run_cmd(1'b0, 1, 1'b1, 3, -1, 1'b0);
        run_cmd(1'b1, 0, 1'b0, 0, -1, 1'b0);
        run_cmd(1'b1, 1, 1'b0, 0, -1, 1'b0);
        run_cmd(1'b1, 3, 1'b0, 2, 6, 1'b0);
        run_cmd(1'b0, 1, 1'b0, 2, -1, 1'b0);
        run_cmd(1'b0, 0, 1'b1, 1, -1, 1'b0);
        run_cmd(1'b1, 255, 1'b0, 1, -1, 1'b0);

        for (int n = 0; n < 40; n++) begin
            int mode;
            mode = $urandom_range(0, 3);
            run_cmd(1'($urandom), $urandom_range(0, 6), 1'($urandom), $urandom_range(0, 5),
                    (mode == 0) ? 0 : -1, (mode == 1));
        end

        repeat (5) @(negedge clk);
        n_tests++;
        if (q.size() != 0) begin
            n_fail++;
            $display("FAIL leftover_events got %0d pending, expected 0", q.size());
        end
        finish_run();
    end

    initial begin
        #500000;
        $display("FAIL watchdog simulation time limit reached");
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail + 1);
        $fatal(1, "watchdog");
    end
endmodule

// File: doc/quad_encoder_emulator.md
Name: quad_encoder_emulator

Overview:
- Transmit-side counterpart of the rotary encoder decoder: synthesises debounce-clean quadrature A/B waveforms and a push-switch level from a command interface.
- Used for closed-loop self-test of the encoder input path, either looped back on-chip or driven out to pins, and for bench stimulus.
- Each command rotates N detents in one direction at a programmable step rate, optionally followed by a switch press/release.

Parameters:
- CNT_W, 8: width of cmd_clicks.
- PERIOD_W, 24: width of step_period and internal step timer.
- PRESS_STEPS, 8: switch hold time and post-release gap, in step periods (must be ≥1).

Ports:
- clk  in  1  system clock.
- reset  in  1  synchronous, active-low reset.
- cmd_valid  in  1  command request.
- cmd_ready  out  1  high only in IDLE; a command is accepted on a clk edge with cmd_valid&&cmd_ready.
- cmd_clockwise  in  1  rotation direction, sampled at accept.
- cmd_clicks  in  CNT_W  detent count, sampled at accept; 1 detent = 4 quadrature steps.
- cmd_press  in  1  append a switch press after rotation, sampled at accept.
- step_period  in  PERIOD_W  clocks per quadrature step (P), sampled at accept; 0 is treated as 1.
- abort  in  1  cancel the active command.
- enc_A  out  1  quadrature phase A (registered).
- enc_B  out  1  quadrature phase B (registered).
- enc_sw  out  1  switch level, 1 = pressed (registered).
- busy  out  1  high in any state other than IDLE.
- step_stb  out  1  1-clk pulse, coincident with each A/B change.
- done_stb  out  1  1-clk pulse at normal command completion.

Behaviour:
- Reset (reset==0 at an edge): enc_A=0, enc_B=0, enc_sw=0, busy=0, step_stb=0, done_stb=0, state=IDLE, timer=0. cmd_ready reads 0 while reset is low and 1 after.
- Phase encoding {B,A}. Clockwise steps: 00→01→11→10→00. CCW steps: 00→10→11→01→00.
- Phase persists across commands; no re-home. Each command performs S=4*cmd_clicks steps starting from the current phase.
- States: IDLE, ROTATE, SETTLE, PRESS, GAP, FINISH.
- Accept at edge t: latch direction, S, press and P (0→1). Timer loads P-1.
  - S>0: go to ROTATE.
  - S==0 and press: go to SETTLE.
  - S==0 and no press: go to FINISH.
- Timer rule: the timer decrements each clk. At 0 it reloads P-1 and causes a tick. Ticks therefore occur at edges t+P, t+2P, and so on.
- ROTATE: each tick advances the phase one step and pulses step_stb. Step k (1..S) is registered at edge t+kP. After step S, go to SETTLE.
- SETTLE: one step period with no change (tick at t+(S+1)P).
  - If press: enc_sw←1 on that edge and go to PRESS.
  - Otherwise go to FINISH.
- PRESS: hold for PRESS_STEPS ticks. enc_sw←0 at edge t+(S+1+PRESS_STEPS)P, then go to GAP.
- GAP: PRESS_STEPS ticks, then go to FINISH.
- FINISH: done_stb=1 for exactly one clk, then IDLE (cmd_ready=1 the following cycle).
- Done edge:
  - No press: t+(S+1)P.
  - With press: t+(S+1+2*PRESS_STEPS)P.
  - S==0 and no press: t+1.
- Abort (any non-IDLE state): IDLE on the next edge.
  - enc_A/enc_B hold their current phase. enc_sw←0. No done_stb. No step_stb on that edge.
  - Abort has priority over a tick on the same edge. Abort in IDLE is ignored.
- cmd_valid while busy is ignored; not queued.
- cmd_clicks at max (255) gives S=1020. The step counter is CNT_W+2 bits wide; no overflow.
- P=1: a step occurs every clk. P is at most 2^PERIOD_W−1.
- Decoder compatibility: P must be ≥ 5*(decoder sample divider+1) clocks. This is a system requirement and is not checked here.

Test Plan:
- Reset low 3 cycles with cmd_valid=1 → all outputs 0, cmd_ready=0; after reset high, cmd_ready=1 and no command is accepted during reset.
- Accept at t: cw, clicks=2, P=4, no press → {B,A} = 01,11,10,00,01,11,10,00 at t+4…t+32; 8 step_stb pulses; done_stb only at t+36; cmd_ready=1 at t+37.
- Accept at t: ccw, clicks=1, P=3, press → {B,A} = 10,11,01,00 at t+3…t+12; enc_sw rises at t+15 and falls at t+39; done_stb at t+63.
- Accept at t: clicks=0, press=0, P=0 → no A/B or enc_sw change; done_stb at t+1. Then cw clicks=1, P=0 → steps every clk, done 5 clks after accept.
- Cw clicks=3, P=2; abort asserted on edge t+6 (a tick edge) → phase stays 11 (2 steps taken), no step_stb on t+6, enc_sw=0, no done_stb, IDLE at t+6. Next ccw command starts from 11→01.
- cmd_valid held high with differing fields during busy → fields ignored; the active command completes with its latched values.
